pipeline_stall_controller: RTL
==============================

Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline's stage-register write enables, bubbles and flushes.
- Combines three inputs:
  - the load-use hazard indication from hazard detection;
  - the taken-branch indication resolved in ID;
  - a multi-cycle data-memory miss handshake from the MEM stage.
- Prioritises them and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB control.
- Also provides stall/flush performance counters and a memory-wait watchdog.

Parameters:
- CNT_W, 32: width of the stall and flush performance counters.
- WAIT_W, 8: width of the internal memory-wait counter.
- TIMEOUT, 200: number of MEM_WAIT cycles without ack before the error state; must satisfy 1 <= TIMEOUT < 2^WAIT_W.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- start_i  input  1  CPU start; sampled only in IDLE.
- loaduse_i  input  1  load-use hazard detected for the instruction in ID.
- branch_i  input  1  branch taken, resolved in ID.
- dmem_miss_i  input  1  MEM-stage access needs external memory; level, held until the instruction leaves MEM.
- dmem_ack_i  input  1  one-cycle pulse; external memory data/write complete.
- dmem_req_o  output  1  memory request; level.
- PCWrite_o  output  1  PC register write enable.
- IFID_Write_o  output  1  IF/ID write enable.
- IFID_Flush_o  output  1  zero the IF/ID instruction field.
- IDEX_Write_o  output  1  ID/EX write enable.
- IDEX_NoOp_o  output  1  select zero control into ID/EX (bubble).
- EXMEM_Write_o  output  1  EX/MEM write enable.
- MEMWB_Bubble_o  output  1  load zero control into MEM/WB.
- stall_cnt_o  output  CNT_W  cycles with PCWrite_o=0 while in RUN or MEM_WAIT; saturating.
- flush_cnt_o  output  CNT_W  cycles with IFID_Flush_o=1; saturating.
- timeout_o  output  1  sticky watchdog error.
- state_o  output  2  current state: IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3.

Behaviour:
- Register and decode structure:
  - Registered: state, wait counter, stall_cnt_o, flush_cnt_o, timeout_o.
  - Combinational (Mealy) from state and inputs: all enables and bubbles, and dmem_req_o.
- Reset (rst_i=0, async):
  - state=IDLE; wait counter, stall_cnt_o, flush_cnt_o and timeout_o all 0.
  - Hence all write enables=0, all bubbles/flushes=0, dmem_req_o=0.
  - Reset in any state, including MEM_WAIT, drops dmem_req_o immediately.
- IDLE:
  - All write enables 0.
  - start_i=1 -> RUN next cycle.
- RUN, decoded in priority order:
  - (1) dmem_miss_i=1 (memory stall):
    - PCWrite, IFID_Write, IDEX_Write, EXMEM_Write = 0; MEMWB_Bubble=1; dmem_req_o=1.
    - loaduse_i and branch_i are ignored this cycle.
    - Next state MEM_WAIT; wait counter cleared to 0.
  - (2) else loaduse_i=1 (load-use):
    - PCWrite=0, IFID_Write=0, IDEX_NoOp=1; IDEX/EXMEM write enables 1.
    - branch_i is ignored; the branch is re-evaluated after the bubble.
  - (3) else branch_i=1: all enables 1, IFID_Flush=1.
  - (4) else: all enables 1, bubbles/flushes 0.
  - dmem_ack_i in RUN is spurious and ignored.
  - start_i has no effect outside IDLE.
- MEM_WAIT:
  - dmem_req_o=1.
  - dmem_ack_i=0:
    - All write enables 0; MEMWB_Bubble=1; wait counter +1.
    - If wait counter = TIMEOUT-1 -> ERROR next.
  - dmem_ack_i=1:
    - Decode as RUN rules (2)-(4); dmem_miss_i is ignored this cycle (it still belongs to the completing instruction).
    - dmem_req_o=1 during this cycle.
    - Next state RUN.
  - Ack wins over timeout in the same cycle.
  - Minimum miss penalty is 1 stall cycle: miss cycle plus ack on the next cycle.
- ERROR:
  - All write enables 0; dmem_req_o=0; timeout_o=1.
  - Held until reset.
- Counters:
  - stall_cnt_o increments on every RUN/MEM_WAIT cycle with PCWrite_o=0.
  - flush_cnt_o increments on every IFID_Flush_o=1 cycle.
  - Both hold at 2^CNT_W-1 (saturate, no wrap).
  - Neither increments in IDLE or ERROR.

Decomposition:
- Shared package:
  - state encoding constants IDLE/RUN/MEM_WAIT/ERROR (2-bit);
  - default CNT_W/WAIT_W/TIMEOUT values.
- Sub-module sat_counter (parameterised width, inc_i, synchronous hold at max, async active-low clear), instantiated twice for the performance counters.

Test Plan:
- Reset, then start_i=1 for 1 cycle -> state_o goes 0->1 one cycle later; all enables 1, counters 0.
- RUN, loaduse_i=1 and branch_i=1 together for 1 cycle -> PCWrite=0, IFID_Write=0, IDEX_NoOp=1, IFID_Flush=0; stall_cnt_o=1, flush_cnt_o=0.
- RUN, branch_i=1 for 1 cycle -> IFID_Flush=1, PCWrite=1; flush_cnt_o=1.
- dmem_miss_i=1 with ack 3 cycles later -> dmem_req_o high for 4 cycles; MEMWB_Bubble=1 for 3 cycles; enables 1 in the ack cycle; stall_cnt_o +=3; state_o returns to 1.
- TIMEOUT=4, miss with no ack -> ERROR entered after 4 MEM_WAIT cycles; timeout_o=1, dmem_req_o=0, state_o=3; rst_i=0 clears it.
- Miss with loaduse_i=1 in the same RUN cycle -> memory stall wins: IDEX_NoOp=0, all enables 0; at ack with loaduse_i=1 -> IDEX_NoOp=1.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg
//   Shared definitions for the pipeline stall controller. It contains the
//   following:
//   - the 2-bit state encoding, which is also visible on state_o;
//   - the default parameter values;
//   - the bundle of per-cycle pipeline controls;
//   - the issue-decode helper that RUN and the MEM_WAIT ack cycle share.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_WAIT_W  = 8;
  localparam int DEF_TIMEOUT = 200;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_noop;
    logic exmem_write;
    logic memwb_bubble;
    logic dmem_req;
  } ctl_t;

  // Normal issue decode when no memory stall is in force.
  // Precedence:
  //   1. A load-use hazard comes first. It holds PC and IF/ID, and it
  //      injects a bubble into ID/EX.
  //   2. Otherwise a taken branch flushes the wrong-path fetch.
  // A branch that arrives together with a load-use hazard is dropped on
  // purpose. The instruction is still in ID after the bubble, so the
  // branch is evaluated again on the next cycle.
  function automatic ctl_t ctl_issue(input logic loaduse, input logic branch);
    ctl_t c;
    c              = '0;
    c.idex_write   = 1'b1;
    c.exmem_write  = 1'b1;
    if (loaduse) begin
      c.idex_noop  = 1'b1;
    end else begin
      c.pc_write   = 1'b1;
      c.ifid_write = 1'b1;
      c.ifid_flush = branch;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter
//   Up-counter that holds at all-ones instead of wrapping.
//   Ports:
//     clk_i    clock
//     rst_i    asynchronous clear, active-low
//     inc_i    increment request for this cycle
//     count_o  current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central sequencer for the 5-stage pipeline. It arbitrates three sources:
//     - a data-memory miss;
//     - a load-use hazard;
//     - a taken branch.
//   From these it drives the stage-register write enables, bubbles and
//   flushes. It also keeps saturating stall and flush counters and a
//   watchdog on the memory wait.
//   Ports:
//     clk_i, rst_i          clock, asynchronous active-low reset
//     start_i               CPU start, only looked at in IDLE
//     loaduse_i, branch_i   hazard and taken-branch indications from ID
//     dmem_miss_i           MEM-stage miss, a level held while the access is in MEM
//     dmem_ack_i            one-cycle completion pulse from external memory
//     dmem_req_o            memory request level
//     PCWrite_o .. MEMWB_Bubble_o   pipeline controls (Mealy)
//     stall_cnt_o, flush_cnt_o      saturating performance counters
//     timeout_o             sticky watchdog error
//     state_o               IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | pipeline frozen, waiting for start_i
//   RUN      | normal issue: memory stall > load-use > branch > advance
//   MEM_WAIT | miss outstanding; pipeline frozen until dmem_ack_i
//   ERROR    | memory never answered; frozen until reset
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WAIT_W  = DEF_WAIT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             loaduse_i,
  input  logic             branch_i,
  input  logic             dmem_miss_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Write_o,
  output logic             IDEX_NoOp_o,
  output logic             EXMEM_Write_o,
  output logic             MEMWB_Bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);

  // The wait count of the last MEM_WAIT cycle allowed before the watchdog fires.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q;
  ctl_t              ctl;
  logic              stall_inc;

  // State register, memory-wait counter and sticky watchdog flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == ST_ERROR) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dmem_miss_i) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        // If the ack and the watchdog limit land in the same cycle, the ack
        // wins, so the data that just arrived is not thrown away.
        if (dmem_ack_i) begin
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode (Mealy).
  // In RUN, a miss takes priority over everything else. In MEM_WAIT,
  // dmem_miss_i is ignored during the ack cycle, because that level still
  // belongs to the instruction that is completing.
  always_comb begin
    ctl = '0;
    unique case (state_q)
      ST_RUN: begin
        if (dmem_miss_i) begin
          ctl.memwb_bubble = 1'b1;
          ctl.dmem_req     = 1'b1;
        end else begin
          ctl = ctl_issue(loaduse_i, branch_i);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          ctl = ctl_issue(loaduse_i, branch_i);
        end else begin
          ctl.memwb_bubble = 1'b1;
        end
        ctl.dmem_req = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

  assign dmem_req_o     = ctl.dmem_req;
  assign PCWrite_o      = ctl.pc_write;
  assign IFID_Write_o   = ctl.ifid_write;
  assign IFID_Flush_o   = ctl.ifid_flush;
  assign IDEX_Write_o   = ctl.idex_write;
  assign IDEX_NoOp_o    = ctl.idex_noop;
  assign EXMEM_Write_o  = ctl.exmem_write;
  assign MEMWB_Bubble_o = ctl.memwb_bubble;
  assign timeout_o      = timeout_q;
  assign state_o        = state_q;

  // A stall is counted only while the pipeline is active. The PC is also
  // held in IDLE and ERROR, but those cycles are not counted.
  assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctl.pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ctl.ifid_flush),
    .count_o (flush_cnt_o)
  );

endmodule
